uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   UART 8N1 transmitter, the send side of the protocol-analyzer UART path. It is
//   used to drive stimulus frames onto a bus whose RX line is watched by the UART
//   trigger receiver. Bytes queue in a small FIFO and are serialized LSB-first.
//   Bit period is set at runtime by baud_cnt, using the same convention as the
//   receiver (baud_cnt+1 clocks per bit).
// PARAMETERS
//   DEPTH   4   FIFO entries; power of 2, >= 2
// PORTS
//   clk       in   1   system clock; all logic on posedge
//   rst       in   1   asynchronous, active-high reset
//   baud_cnt  in   16  clocks per bit minus 1
//   wr_en     in   1   push wr_data into FIFO this cycle
//   wr_data   in   8   byte to send
//   full      out  1   FIFO holds DEPTH entries
//   empty     out  1   FIFO holds 0 entries
//   overflow  out  1   1-cycle pulse: wr_en asserted while full; byte dropped
//   TX        out  1   serial line; idle high
//   tx_busy   out  1   frame in progress (start bit through stop bit)
//   tx_done   out  1   1-cycle pulse at the end of each stop bit
// BEHAVIOUR
//   Reset values: TX=1, tx_busy=0, tx_done=0, overflow=0, full=0, empty=1.
//     FIFO pointers/count=0, state=IDLE.
//   Reset mid-frame: TX returns high at once (async), queued bytes are discarded,
//     and no tx_done is produced.
//   FIFO: full/empty decode the registered count.
//     - wr_en && !full -> push.
//     - wr_en && full  -> drop the byte and pulse overflow next cycle, even if a
//       pop happens the same cycle.
//     - A push and a pop in the same cycle leave the count unchanged.
//     - Pointers wrap modulo DEPTH.
//   FSM, two states:
//     IDLE:  TX=1. If !empty: pop the head, load shreg={1'b1,byte,1'b0}, latch
//            baud_cnt into bit_len, clear baud_ctr and bit_idx -> SHIFT.
//     SHIFT: TX=shreg[0] (registered). baud_ctr counts 0..bit_len.
//            - At bit_len: baud_ctr<=0, shreg>>=1, bit_idx++.
//            - When bit_idx==9 && baud_ctr==bit_len (stop bit complete):
//              pulse tx_done.
//              - If !empty: pop, reload, relatch baud_cnt, stay in SHIFT. The
//                next start bit begins on the next cycle, with no idle gap.
//              - Else -> IDLE.
//   tx_busy = (state==SHIFT).
//   Latency: wr_en at cycle N into an empty, idle block -> pop at N+1 -> TX=0
//     from N+2.
//   Each bit is held exactly bit_len+1 clocks. A frame is 10*(bit_len+1) clocks.
//   baud_cnt changes mid-frame have no effect until the next frame load.
//     baud_cnt=0 is legal (1 clock per bit).
//   baud_ctr is 16 bits and never exceeds bit_len. bit_idx is 4 bits, range 0..9.
// TESTING
//   1. Reset with baud_cnt=3, then write 0xA5 once -> TX=0 from the 2nd cycle
//      after the write. Then 1,0,1,0,0,1,0,1,1, each bit 4 clocks wide.
//      tx_done pulses at clock 40 of the frame, and tx_busy then drops.
//   2. baud_cnt=0: write 0x00, 0xFF, 0x3C back-to-back -> 30 contiguous bit
//      cells and 3 tx_done pulses. There is no idle cycle between frames.
//   3. DEPTH=4 with TX busy: write 5 bytes -> full=1 after the 4th, and overflow
//      pulses for the 5th. The sent bytes are 1st..4th in order, and empty=1
//      at the end.
//   4. During a frame, push and pop collide with the FIFO at count 2 -> count
//      stays 2, and no data is lost or duplicated.
//   5. Change baud_cnt 3->7 mid-frame -> the current frame keeps 4-clock bits,
//      and the next frame uses 8-clock bits.
//   6. Assert rst during data bit 3 -> TX=1 the same cycle. empty=1 and
//      tx_done=0, and no output activity until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO; bytes leave LSB-first.
// Each bit lasts baud_cnt_i+1 clocks, sampled once per frame at load time.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] baud_cnt_i,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_data_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        overflow_o,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        tx_done_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          push, pop;
    logic [7:0]    head;

    logic [9:0]    shreg_q;
    logic [15:0]   bit_len_q, baud_ctr_q;
    logic [3:0]    bit_idx_q;
    logic          bit_end, stop_end;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign overflow_o = overflow_q;
    assign push       = wr_en_i && !full_o;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en_i && full_o;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign bit_end  = (baud_ctr_q == bit_len_q);
    assign stop_end = bit_end && (bit_idx_q == 4'd9);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_o) state_d = SHIFT;
            SHIFT:   if (stop_end && empty_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        tx_o      = 1'b1;
        tx_busy_o = 1'b0;
        tx_done_o = 1'b0;
        case (state_q)
            IDLE: pop = !empty_o;
            SHIFT: begin
                tx_o      = shreg_q[0];
                tx_busy_o = 1'b1;
                tx_done_o = stop_end;
                pop       = stop_end && !empty_o;
            end
            default: ;
        endcase
    end

    // A pop always starts a fresh frame, including back-to-back reloads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q    <= '1;
            bit_len_q  <= '0;
            baud_ctr_q <= '0;
            bit_idx_q  <= '0;
        end else if (pop) begin
            shreg_q    <= {1'b1, head, 1'b0};
            bit_len_q  <= baud_cnt_i;
            baud_ctr_q <= '0;
            bit_idx_q  <= '0;
        end else if (state_q == SHIFT) begin
            if (stop_end) begin
                baud_ctr_q <= '0;
            end else if (bit_end) begin
                baud_ctr_q <= '0;
                shreg_q    <= {1'b1, shreg_q[9:1]};
                bit_idx_q  <= bit_idx_q + 4'd1;
            end else begin
                baud_ctr_q <= baud_ctr_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: written bytes go to a scoreboard with their
// expected bit length; a line monitor decodes each frame and compares it.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_cnt = 16'd3;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        full, empty, overflow, tx, tx_busy, tx_done;

    uart_tx_fifo #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .baud_cnt_i(baud_cnt),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(full), .empty_o(empty), .overflow_o(overflow),
        .tx_o(tx), .tx_busy_o(tx_busy), .tx_done_o(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int len; } item_t;
    item_t sb[$];
    int    starts[$];
    int    dones[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int frames_done = 0, spurious = 0, idle_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: frame shape, tx_done position and byte value per frame.
    item_t      cur;
    bit         in_frame = 1'b0;
    bit         shape_ok;
    logic [7:0] rx;
    logic       exp_line;
    int         k, bit_n, pos;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    if (sb.size() == 0) spurious++;
                    else begin
                        cur = sb.pop_front();
                        in_frame = 1'b1; k = 0; shape_ok = 1'b1; rx = '0;
                        starts.push_back(cyc);
                    end
                end else if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                    idle_err++;
                end
            end
            if (in_frame) begin
                bit_n = k / (cur.len + 1);
                pos   = k % (cur.len + 1);
                exp_line = (bit_n == 0) ? 1'b0 : (bit_n == 9) ? 1'b1 : cur.data[bit_n-1];
                if (tx !== exp_line || tx_busy !== 1'b1 ||
                    tx_done !== (k == 10*(cur.len+1) - 1)) shape_ok = 1'b0;
                if (bit_n >= 1 && bit_n <= 8 && pos == cur.len/2) rx[bit_n-1] = tx;
                k++;
                if (k == 10*(cur.len+1)) begin
                    n_cmp++;
                    assert (rx === cur.data) else begin
                        n_err++;
                        $error("FAIL frame_byte: observed %02h expected %02h", rx, cur.data);
                    end
                    n_cmp++;
                    assert (shape_ok === 1'b1) else begin
                        n_err++;
                        $error("FAIL frame_shape: byte %02h len %0d observed bad expected clean", cur.data, cur.len);
                    end
                    dones.push_back(cyc);
                    frames_done++;
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [7:0] d, input int len, input bit sent);
        wr_en = 1'b1; wr_data = d;
        if (sent) sb.push_back('{data: d, len: len});
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames_done >= target) break;
            tick();
        end
        check("wait_frames", 32'(frames_done >= target), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_cyc, n0, si, s, ns, sp, ie;
        logic [7:0] b [5];
        b[0] = 8'h21; b[1] = 8'h42; b[2] = 8'h84; b[3] = 8'h18; b[4] = 8'hEE;

        // 1: reset values, latency and a single 0xA5 frame at 4 clocks/bit
        repeat (3) tick();
        check("rst_tx", tx, 1); check("rst_busy", tx_busy, 0); check("rst_empty", empty, 1);
        rst = 1'b0;
        tick();
        check("idle_tx", tx, 1); check("idle_busy", tx_busy, 0); check("idle_done", tx_done, 0);
        check("idle_ovf", overflow, 0); check("idle_full", full, 0); check("idle_empty", empty, 1);
        put(8'hA5, 3, 1'b1);
        wr_cyc = cyc;
        check("pop_cycle_tx", tx, 1);
        wait_frames(1, 100);
        check("latency", starts[0], wr_cyc + 1);
        tick();
        check("busy_drop", tx_busy, 0);

        // 2: one clock per bit, three frames with no idle gap
        baud_cnt = 16'd0;
        n0 = frames_done; si = starts.size();
        put(8'h00, 0, 1'b1); put(8'hFF, 0, 1'b1); put(8'h3C, 0, 1'b1);
        wait_frames(n0 + 3, 200);
        check("contiguous_30", dones[dones.size()-1] - starts[si], 29);

        // 3: fill to full while busy, fifth write overflows and is dropped
        baud_cnt = 16'd3;
        n0 = frames_done;
        put(8'h11, 3, 1'b1);
        repeat (3) tick();
        check("busy_before_burst", tx_busy, 1);
        for (int i = 0; i < 5; i++) begin
            put(b[i], 3, i < 4);
            if (i == 3) check("full_after_4", full, 1);
            if (i == 4) check("ovf_pulse", overflow, 1);
        end
        tick();
        check("ovf_one_cycle", overflow, 0);
        wait_frames(n0 + 5, 400);
        check("empty_after_drain", empty, 1);

        // 4: push and pop collide at count 2
        n0 = frames_done;
        put(8'h5A, 3, 1'b1); put(8'hC3, 3, 1'b1); put(8'h0F, 3, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (tx_done === 1'b1) break;
            tick();
        end
        check("collide_sync", tx_done, 1);
        put(8'h99, 3, 1'b1);
        check("collide_not_empty", empty, 0);
        check("collide_not_full", full, 0);
        put(8'h77, 3, 1'b1); put(8'h12, 3, 1'b1);
        check("count_back_to_4", full, 1);
        check("no_ovf_at_4", overflow, 0);
        wait_frames(n0 + 6, 600);
        check("empty_after_collide", empty, 1);

        // 5: baud change mid-frame only affects the next frame
        n0 = frames_done;
        put(8'h96, 3, 1'b1); put(8'h69, 7, 1'b1);
        repeat (8) tick();
        baud_cnt = 16'd7;
        wait_frames(n0 + 2, 300);
        check("slow_frame_len", dones[dones.size()-1] - starts[starts.size()-1], 79);

        // 6: reset during data bit 3 aborts everything
        baud_cnt = 16'd3;
        ns = starts.size();
        put(8'hF7, 3, 1'b1); put(8'h55, 3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (starts.size() > ns) break;
            tick();
        end
        check("abort_frame_started", 32'(starts.size() > ns), 1);
        s = (starts.size() > ns) ? starts[ns] : cyc;
        for (int i = 0; i < 40; i++) begin
            if (cyc >= s + 17) break;
            tick();
        end
        check("pre_rst_tx", tx, 0);
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_tx_async", tx, 1);
        check("rst_empty_async", empty, 1);
        check("rst_done_async", tx_done, 0);
        check("rst_busy_async", tx_busy, 0);
        tick(); tick();
        rst = 1'b0;
        n0 = frames_done; sp = spurious; ie = idle_err;
        repeat (60) tick();
        check("quiet_frames", frames_done, n0);
        check("quiet_spurious", spurious, sp);
        check("quiet_idle", idle_err, ie);
        put(8'h3E, 3, 1'b1);
        wait_frames(n0 + 1, 100);

        tick();
        check("sb_drained", sb.size(), 0);
        check("spurious_total", spurious, 0);
        check("idle_err_total", idle_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
